// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipeline: opcodes, instruction field
// positions, forwarding select encodings and the MUL sequencer states.
package pipe_pkg;

   localparam int INSTR_W = 16;
   localparam int FIELD_W = 4;

   // instruction field positions (LSB of each 4-bit field)
   localparam int OP_LSB  = 12;
   localparam int HI_LSB  = 8;
   localparam int MID_LSB = 4;
   localparam int LO_LSB  = 0;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;
   localparam logic [3:0] OP_ADDI = 4'd10;
   localparam logic [3:0] OP_LD   = 4'd11;
   localparam logic [3:0] OP_ST   = 4'd12;
   localparam logic [3:0] OP_BZ   = 4'd13;
   localparam logic [3:0] OP_JMP  = 4'd14;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef enum logic {
      MUL_IDLE = 1'b0,
      MUL_BUSY = 1'b1
   } mul_state_e;

   // ops 1..11 write the register file
   function automatic logic is_writer(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_LD);
   endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational instruction decode: register fields and their usage flags.
// Unused fields are driven to zero so downstream compares stay quiet.
module instr_fields
   import pipe_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output logic [3:0]         op,
   output logic [FIELD_W-1:0] dst,
   output logic [FIELD_W-1:0] src_a,
   output logic [FIELD_W-1:0] src_b,
   output logic               uses_a,
   output logic               uses_b,
   output logic               writes
);

   // split the instruction by opcode class
   always_comb begin
      op     = instr[OP_LSB +: 4];
      dst    = '0;
      src_a  = '0;
      src_b  = '0;
      uses_a = 1'b0;
      uses_b = 1'b0;
      writes = is_writer(op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
         OP_SHL, OP_SHR, OP_SLT, OP_MUL: begin
            dst    = instr[HI_LSB +: FIELD_W];
            src_a  = instr[MID_LSB +: FIELD_W];
            src_b  = instr[LO_LSB +: FIELD_W];
            uses_a = 1'b1;
            uses_b = 1'b1;
         end
         OP_ADDI, OP_LD: begin
            dst    = instr[HI_LSB +: FIELD_W];
            src_a  = instr[MID_LSB +: FIELD_W];
            uses_a = 1'b1;
         end
         OP_ST: begin
            // store data rides the B path, base address the A path
            src_a  = instr[MID_LSB +: FIELD_W];
            src_b  = instr[HI_LSB +: FIELD_W];
            uses_a = 1'b1;
            uses_b = 1'b1;
         end
         OP_BZ: begin
            src_a  = instr[HI_LSB +: FIELD_W];
            uses_a = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline sequencing controller: load-use stall, MUL hold, branch/jump
// flush and EX operand forwarding, driven from a private EX shadow.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   MUL_IDLE | no multi-cycle op in progress; a MUL arriving in EX
//            | starts the hold and loads the down-counter
//   MUL_BUSY | MUL held in EX; holds while counter != 0, releases at 0
module hazard_unit
   import pipe_pkg::*;
#(
   parameter int MUL_CYCLES = 3,
   parameter int REG_AW     = 4
)
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic [INSTR_W-1:0] id_instr,
   input  logic               branch_taken,
   input  logic [REG_AW-1:0]  mem_dst,
   input  logic               mem_wb_en,
   input  logic [REG_AW-1:0]  wb_dst,
   input  logic               wb_wb_en,
   output logic               pc_stall,
   output logic               if_id_stall,
   output logic               if_id_flush,
   output logic               id_ex_bubble,
   output logic               ex_hold,
   output logic [1:0]         fwd_a,
   output logic [1:0]         fwd_b,
   output logic               mul_busy
);

   localparam logic       MUL_MULTI = (MUL_CYCLES > 1);
   localparam logic [3:0] CNT_LOAD  = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

   logic [3:0]         id_op;
   logic [FIELD_W-1:0] id_dst, id_a, id_b;
   logic               id_uses_a, id_uses_b, id_writes;

   logic [3:0]         ex_op_q, ex_op_d;
   logic [REG_AW-1:0]  ex_dst_q, ex_dst_d;
   logic [REG_AW-1:0]  ex_a_q, ex_a_d;
   logic [REG_AW-1:0]  ex_b_q, ex_b_d;
   logic               ex_uses_a_q, ex_uses_a_d;
   logic               ex_uses_b_q, ex_uses_b_d;

   mul_state_e         state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               mul_busy_q;

   logic               ex_hold_c, load_use_c;
   logic               pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_bubble_c;
   logic [1:0]         fwd_a_c, fwd_b_c;

   instr_fields u_id_fields (
      .instr  (id_instr),
      .op     (id_op),
      .dst    (id_dst),
      .src_a  (id_a),
      .src_b  (id_b),
      .uses_a (id_uses_a),
      .uses_b (id_uses_b),
      .writes (id_writes)
   );

   function automatic logic [1:0] fwd_sel(
      input logic              uses,
      input logic [REG_AW-1:0] src,
      input logic [REG_AW-1:0] m_dst,
      input logic              m_en,
      input logic [REG_AW-1:0] w_dst,
      input logic              w_en
   );
      if (!uses || (src == '0))       return FWD_RF;
      else if (m_en && (m_dst == src)) return FWD_MEM;
      else if (w_en && (w_dst == src)) return FWD_WB;
      else                             return FWD_RF;
   endfunction

   // MUL sequencer next state and EX hold
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ex_hold_c = 1'b0;
      case (state_q)
         MUL_IDLE: begin
            if ((ex_op_q == OP_MUL) && MUL_MULTI) begin
               ex_hold_c = 1'b1;
               state_d   = MUL_BUSY;
               cnt_d     = CNT_LOAD;
            end
         end
         MUL_BUSY: begin
            if (cnt_q != 4'd0) begin
               ex_hold_c = 1'b1;
               cnt_d     = cnt_q - 4'd1;
            end else begin
               state_d = MUL_IDLE;
            end
         end
         default: state_d = MUL_IDLE;
      endcase
   end

   // stall / flush / bubble arbitration, hold wins over everything
   always_comb begin
      load_use_c = (ex_op_q == OP_LD) && (ex_dst_q != '0) &&
                   ((id_uses_a && (REG_AW'(id_a) == ex_dst_q)) ||
                    (id_uses_b && (REG_AW'(id_b) == ex_dst_q)));
      pc_stall_c      = 1'b0;
      if_id_stall_c   = 1'b0;
      if_id_flush_c   = 1'b0;
      id_ex_bubble_c  = 1'b0;
      if (ex_hold_c) begin
         pc_stall_c    = 1'b1;
         if_id_stall_c = 1'b1;
      end else if (branch_taken) begin
         if_id_flush_c  = 1'b1;
         id_ex_bubble_c = 1'b1;
      end else if (load_use_c) begin
         pc_stall_c     = 1'b1;
         if_id_stall_c  = 1'b1;
         id_ex_bubble_c = 1'b1;
      end else if (id_op == OP_JMP) begin
         if_id_flush_c = 1'b1;
      end
   end

   // operand forwarding from the EX shadow, MEM beats WB
   always_comb begin
      fwd_a_c = fwd_sel(ex_uses_a_q, ex_a_q, mem_dst, mem_wb_en, wb_dst, wb_wb_en);
      fwd_b_c = fwd_sel(ex_uses_b_q, ex_b_q, mem_dst, mem_wb_en, wb_dst, wb_wb_en);
   end

   // EX shadow next value: hold, bubble to NOP, or take the ID decode
   always_comb begin
      ex_op_d     = ex_op_q;
      ex_dst_d    = ex_dst_q;
      ex_a_d      = ex_a_q;
      ex_b_d      = ex_b_q;
      ex_uses_a_d = ex_uses_a_q;
      ex_uses_b_d = ex_uses_b_q;
      if (!ex_hold_c) begin
         if (id_ex_bubble_c) begin
            ex_op_d     = OP_NOP;
            ex_dst_d    = '0;
            ex_a_d      = '0;
            ex_b_d      = '0;
            ex_uses_a_d = 1'b0;
            ex_uses_b_d = 1'b0;
         end else begin
            ex_op_d     = id_op;
            ex_dst_d    = id_writes ? REG_AW'(id_dst) : '0;
            ex_a_d      = REG_AW'(id_a);
            ex_b_d      = REG_AW'(id_b);
            ex_uses_a_d = id_uses_a;
            ex_uses_b_d = id_uses_b;
         end
      end
   end

   // EX shadow registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ex_op_q     <= OP_NOP;
         ex_dst_q    <= '0;
         ex_a_q      <= '0;
         ex_b_q      <= '0;
         ex_uses_a_q <= 1'b0;
         ex_uses_b_q <= 1'b0;
      end else begin
         ex_op_q     <= ex_op_d;
         ex_dst_q    <= ex_dst_d;
         ex_a_q      <= ex_a_d;
         ex_b_q      <= ex_b_d;
         ex_uses_a_q <= ex_uses_a_d;
         ex_uses_b_q <= ex_uses_b_d;
      end
   end

   // MUL sequencer state, counter and registered busy flag
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= MUL_IDLE;
         cnt_q      <= 4'd0;
         mul_busy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mul_busy_q <= (state_d == MUL_BUSY);
      end
   end

   // outputs forced low while reset is asserted, since several depend on inputs
   assign pc_stall     = reset_n & pc_stall_c;
   assign if_id_stall  = reset_n & if_id_stall_c;
   assign if_id_flush  = reset_n & if_id_flush_c;
   assign id_ex_bubble = reset_n & id_ex_bubble_c;
   assign ex_hold      = reset_n & ex_hold_c;
   assign fwd_a        = {2{reset_n}} & fwd_a_c;
   assign fwd_b        = {2{reset_n}} & fwd_b_c;
   assign mul_busy     = reset_n & mul_busy_q;

endmodule
